// File: rtl/pipelined_left_shifter.sv
// pipelined_left_shifter
//   Logical shift-left or rotate-left of a WIDTH-bit word by 0..WIDTH-1
//   positions. The shifter has SHW = log2(WIDTH) registered stages. Stage k
//   conditionally shifts by 2^k, starting with the LSB stage. The pipeline
//   uses a valid/ready handshake with backpressure.
//
//   Optional feature macro: PLS_OVF_FLAG_EN. When it is defined, the out_ovf
//   port is present. out_ovf flags that a logical shift pushed at least one
//   '1' out of the MSB.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   stage 0 can accept (transfer on in_valid & in_ready)
//   in_data    operand
//   in_shamt   left shift amount
//   in_rotate  1 = rotate-left, 0 = logical (zero fill)
//   out_valid  out_data valid
//   out_ready  consumer accepts (transfer on out_valid & out_ready)
//   out_data   shifted/rotated result
//   out_ovf    shifted-out-one flag (PLS_OVF_FLAG_EN only)
module pipelined_left_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_rotate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PLS_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : stg
            localparam int AMT = 1 << k;

            // Upstream view. The shamt width shrinks by one bit per stage
            // because each stage consumes bit 0 and forwards the rest.
            logic             up_vld;
            logic [WIDTH-1:0] up_dat;
            logic [SHW-k-1:0] up_sh;
            logic             up_rot;
            logic             nxt_rdy;
            logic             rdy;
            logic             vld_q;
            logic [WIDTH-1:0] dat_q;
            logic [WIDTH-1:0] dat_d;

            if (k == 0) begin : g_src
                assign up_vld = in_valid;
                assign up_dat = in_data;
                assign up_sh  = in_shamt;
                assign up_rot = in_rotate;
            end else begin : g_src
                assign up_vld = stg[k-1].vld_q;
                assign up_dat = stg[k-1].dat_q;
                assign up_sh  = stg[k-1].g_fwd.sh_q;
                assign up_rot = stg[k-1].g_fwd.rot_q;
            end

            if (k == SHW-1) begin : g_nrdy
                assign nxt_rdy = out_ready;
            end else begin : g_nrdy
                assign nxt_rdy = stg[k+1].rdy;
            end

            // An empty slot, or a slot that drains this cycle, can load.
            assign rdy = ~vld_q | nxt_rdy;

            // For a rotate, the bits leaving the MSB are ORed back in at the
            // LSB. Shifting in the opposite direction by WIDTH-AMT moves them
            // there.
            assign dat_d = up_sh[0]
                         ? ((up_dat << AMT) | (up_rot ? (up_dat >> (WIDTH - AMT)) : '0))
                         : up_dat;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else if (rdy) begin
                    vld_q <= up_vld;
                    dat_q <= dat_d;
                end
            end

            // The last stage needs no control forwarding.
            if (k < SHW-1) begin : g_fwd
                logic [SHW-k-2:0] sh_q;
                logic             rot_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sh_q  <= '0;
                        rot_q <= 1'b0;
                    end else if (rdy) begin
                        sh_q  <= up_sh[SHW-k-1:1];
                        rot_q <= up_rot;
                    end
                end
            end

`ifdef PLS_OVF_FLAG_EN
            logic up_ovf;
            logic ovf_d;
            logic ovf_q;
            if (k == 0) begin : g_ovf_src
                assign up_ovf = 1'b0;
            end else begin : g_ovf_src
                assign up_ovf = stg[k-1].ovf_q;
            end
            // A one is lost when this stage shifts logically and any of the
            // top AMT bits it pushes out is set.
            assign ovf_d = up_ovf | (up_sh[0] & ~up_rot & (|up_dat[WIDTH-1 -: AMT]));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   ovf_q <= 1'b0;
                else if (rdy) ovf_q <= ovf_d;
            end
`endif
        end
    endgenerate

    assign in_ready  = stg[0].rdy;
    assign out_valid = stg[SHW-1].vld_q;
    assign out_data  = stg[SHW-1].dat_q;
`ifdef PLS_OVF_FLAG_EN
    assign out_ovf   = stg[SHW-1].ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_left_shifter.sv
// Testbench for pipelined_left_shifter (WIDTH = 32). The expected results
// come from a bit-serial reference model and an in-order scoreboard. The
// bench also uses directed vectors with literal expectations. It follows
// PLS_OVF_FLAG_EN to decide whether out_ovf is connected and checked.
module tb_pipelined_left_shifter;
    localparam int W   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [SHW-1:0] in_shamt;
    logic           in_rotate;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
`ifdef PLS_OVF_FLAG_EN
    logic           out_ovf;
`endif

    pipelined_left_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_rotate (in_rotate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PLS_OVF_FLAG_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: shift one bit position at a time.
    function automatic logic [W-1:0] mdl(input logic [W-1:0] d, input int sh, input bit rot);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < sh; i++)
            r = rot ? {r[W-2:0], r[W-1]} : {r[W-2:0], 1'b0};
        return r;
    endfunction

    function automatic bit mdl_ovf(input logic [W-1:0] d, input int sh, input bit rot);
        bit o;
        o = 1'b0;
        if (!rot)
            for (int i = 0; i < sh; i++)
                if (d[W-1-i]) o = 1'b1;
        return o;
    endfunction

    logic [W-1:0] q_dat[$];
    bit           q_ovf[$];
    bit           hold;
    logic [W-1:0] hold_dat;

    // Scoreboard and stall-stability checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_dat.delete();
            q_ovf.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(hold_dat));
            end
            if (out_valid && out_ready) begin
                if (q_dat.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    chk("out_data", 64'(out_data), 64'(q_dat[0]));
`ifdef PLS_OVF_FLAG_EN
                    chk("out_ovf", 64'(out_ovf), 64'(q_ovf[0]));
`endif
                    void'(q_dat.pop_front());
                    void'(q_ovf.pop_front());
                    pops++;
                end
            end
            hold     = out_valid && !out_ready;
            hold_dat = out_data;
            if (in_valid && in_ready) begin
                q_dat.push_back(mdl(in_data, int'(in_shamt), in_rotate));
                q_ovf.push_back(mdl_ovf(in_data, int'(in_shamt), in_rotate));
            end
        end
    end

    task automatic send1(input logic [W-1:0] d, input int sh, input bit rot,
                         input logic [W-1:0] exp, input bit exp_ovf, input string nm);
        int n;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = sh[SHW-1:0];
        in_rotate = rot;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd5);
        chk({nm, "_data"}, 64'(out_data), 64'(exp));
`ifdef PLS_OVF_FLAG_EN
        chk({nm, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
`else
        if (exp_ovf) n = 0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int run, maxrun, p0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_rotate = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        send1(32'h0000_0001, 31, 1'b0, 32'h8000_0000, 1'b0, "lsl31");
        send1(32'h8000_0001,  4, 1'b0, 32'h0000_0010, 1'b1, "lsl4");
        send1(32'h8000_0001,  1, 1'b1, 32'h0000_0003, 1'b0, "rol1");
        send1(32'h1234_5678,  8, 1'b1, 32'h3456_7812, 1'b0, "rol8");
        send1(32'hDEAD_BEEF,  0, 1'b0, 32'hDEAD_BEEF, 1'b0, "sh0");

        // Throughput: 32 back-to-back words.
        run = 0; maxrun = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (c < 32) begin
                in_valid  = 1'b1;
                in_data   = 32'hA5A5_A5A5;
                in_shamt  = c[SHW-1:0];
                in_rotate = c[0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        chk("thru_consecutive", 64'(maxrun), 64'd32);

        // Backpressure: fill with 5 words, then stall for 10 cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_data   = 32'h0000_0011;
            in_shamt  = i[SHW-1:0];
            in_rotate = 1'b0;
            #1 chk("bp_fill_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        in_data = 32'hFFFF_FFFF;
        in_shamt = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_data", 64'(out_data), 64'h11);
            @(posedge clk); #1;
        end
        p0 = pops;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_drained", 64'(pops - p0), 64'd5);
        chk("bp_queue_empty", 64'(q_dat.size()), 64'd0);

        // Mid-stream reset with three words in flight.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_data   = 32'h0000_0003;
            in_shamt  = 5'd1;
            in_rotate = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_data", 64'(out_data), 64'h6);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_shamt  = ($urandom_range(0, 7) == 0) ? '0 : SHW'($urandom);
            in_rotate = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_drained", 64'(q_dat.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
